// File: rtl/imem_fetch_sequencer.sv
// Y86-64 fetch sequencer: one byte read per cycle from a synchronous imem, length decode, 10-byte window handoff.
// Optional IFETCH_PERF_EN adds acceptance and stall counters.
module imem_fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] MEM_LAST = 64'd1023
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [63:0] inst_pc,
  output logic [79:0] inst_bytes,
  output logic [3:0]  inst_len,
  output logic        inst_err,
  output logic        inst_ins_err
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_inst_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int MAX_LEN = 10;

  typedef enum logic [1:0] {FETCH, HOLD, STOP} state_t;

  state_t                    state;
  logic [MAX_LEN-1:0][7:0]   win_q;
  logic [3:0]                cnt_iss, rcv_cnt, rd_idx, len_q;
  logic                      rd_pend, len_known, ins_q, blocked;

  // 64-bit unsigned compare; a carry out of base+k is itself out of range
  function automatic logic addr_ok(input logic [63:0] base, input logic [3:0] k);
    logic [64:0] a;
    a = {1'b0, base} + {61'd0, k};
    return !a[64] && (a[63:0] <= MEM_LAST);
  endfunction

  // {ins_err, len}
  function automatic logic [4:0] decode(input logic [3:0] icode);
    case (icode)
      4'h0, 4'h1, 4'h9:       decode = {1'b0, 4'd1};
      4'h2, 4'h6, 4'hA, 4'hB: decode = {1'b0, 4'd2};
      4'h7, 4'h8:             decode = {1'b0, 4'd9};
      4'h3, 4'h4, 4'h5:       decode = {1'b0, 4'd10};
      default:                decode = {1'b1, 4'd1};
    endcase
  endfunction

  logic        byte0_now, dec_ins, cur_known, cur_ins, want, nxt_ok, keep;
  logic        norm_done, err_done, accept, halt_acc, start, start_ok;
  logic [3:0]  dec_len, cur_len, cap, rcv_n;
  logic [63:0] succ_pc, start_pc;

  assign byte0_now        = rd_pend && (rd_idx == 4'd0);
  assign {dec_ins, dec_len} = decode(mem_rdata[7:4]);
  assign cur_known        = len_known || byte0_now;
  assign cur_len          = byte0_now ? dec_len : len_q;
  assign cur_ins          = byte0_now ? dec_ins : ins_q;
  // until byte 0 is back only byte 1 may be issued speculatively
  assign cap              = cur_known ? cur_len : 4'd2;
  assign want             = !blocked && (cnt_iss < cap);
  assign nxt_ok           = addr_ok(inst_pc, cnt_iss);
  assign rcv_n            = rcv_cnt + {3'd0, rd_pend};
  assign keep             = rd_pend && cur_known && (rd_idx < cur_len);
  assign norm_done        = cur_known && (rcv_n >= cur_len);
  assign err_done         = (blocked || (want && !nxt_ok)) && (rcv_n == cnt_iss) && !norm_done;

  assign accept   = inst_valid && inst_ready;
  assign halt_acc = inst_err || inst_ins_err || (win_q[0][7:4] == 4'h0);
  assign succ_pc  = inst_pc + {60'd0, inst_len};
  assign start    = redirect_valid || (state == HOLD && accept && !halt_acc);
  assign start_pc = redirect_valid ? redirect_pc : succ_pc;
  assign start_ok = addr_ok(start_pc, 4'd0);

  assign inst_bytes = win_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FETCH;
      mem_req      <= 1'b0;
      mem_addr     <= RESET_PC;
      inst_pc      <= RESET_PC;
      inst_valid   <= 1'b0;
      inst_len     <= 4'd0;
      inst_err     <= 1'b0;
      inst_ins_err <= 1'b0;
      win_q        <= '0;
      cnt_iss      <= 4'd0;
      rcv_cnt      <= 4'd0;
      rd_idx       <= 4'd0;
      rd_pend      <= 1'b0;
      len_q        <= 4'd0;
      len_known    <= 1'b0;
      ins_q        <= 1'b0;
      blocked      <= 1'b0;
    end else begin
      rd_pend <= mem_req;
      rd_idx  <= cnt_iss - 4'd1;
      if (start) begin
        // redirect or successor fetch; data still in flight is dropped
        state        <= FETCH;
        inst_pc      <= start_pc;
        mem_req      <= start_ok;
        mem_addr     <= start_pc;
        cnt_iss      <= start_ok ? 4'd1 : 4'd0;
        blocked      <= !start_ok;
        rcv_cnt      <= 4'd0;
        rd_pend      <= 1'b0;
        len_known    <= 1'b0;
        inst_valid   <= 1'b0;
        inst_err     <= 1'b0;
        inst_ins_err <= 1'b0;
        win_q        <= '0;
      end else begin
        case (state)
          FETCH: begin
            if (keep) win_q[rd_idx] <= mem_rdata;
            if (byte0_now) begin
              len_known <= 1'b1;
              len_q     <= dec_len;
              ins_q     <= dec_ins;
            end
            rcv_cnt <= rcv_n;
            mem_req <= want && nxt_ok;
            if (want) begin
              if (nxt_ok) begin
                mem_addr <= inst_pc + {60'd0, cnt_iss};
                cnt_iss  <= cnt_iss + 4'd1;
              end else begin
                blocked  <= 1'b1;
              end
            end
            if (norm_done || err_done) begin
              state        <= HOLD;
              inst_valid   <= 1'b1;
              inst_len     <= cur_known ? cur_len : 4'd1;
              inst_err     <= err_done;
              inst_ins_err <= cur_known && cur_ins;
            end
          end
          HOLD: begin
            // only terminal windows get here; normal successors go through start
            if (accept) begin
              state      <= STOP;
              inst_valid <= 1'b0;
              inst_pc    <= succ_pc;
              win_q      <= '0;
            end
          end
          STOP:    ;
          default: state <= STOP;
        endcase
      end
    end
  end

`ifdef IFETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_inst_cnt  <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (accept)                    perf_inst_cnt  <= perf_inst_cnt + 32'd1;
      if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a byte memory model and an expected-window scoreboard.
module tb_imem_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [63:0] inst_pc;
  logic [79:0] inst_bytes;
  logic [3:0]  inst_len;
  logic        inst_err, inst_ins_err;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_inst_cnt, perf_stall_cnt;
`endif

  imem_fetch_sequencer dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc),
    .inst_bytes(inst_bytes), .inst_len(inst_len),
    .inst_err(inst_err), .inst_ins_err(inst_ins_err)
`ifdef IFETCH_PERF_EN
    , .perf_inst_cnt(perf_inst_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:1023];
  always @(posedge clk)
    if (mem_req) mem_rdata <= (mem_addr <= 64'd1023) ? mem[mem_addr[9:0]] : 8'hEE;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  len;
    logic [79:0] bytes;
    logic        err;
    logic        ins;
    int          vcyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] req_log[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (mem_req) req_log.push_back(mem_addr);
  endtask

  task automatic push(input logic [63:0] pc, input logic [3:0] len, input logic [79:0] bytes,
                      input logic err, input logic ins, input int vcyc);
    exp_t e;
    e.pc = pc; e.len = len; e.bytes = bytes; e.err = err; e.ins = ins; e.vcyc = vcyc;
    exp_q.push_back(e);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_ready = 1'b0; redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst pc", inst_pc, 0);
    chk("rst valid", inst_valid, 0);
    rst = 1'b0;
    req_log.delete();
    tick();
    cyc = 0;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    req_log.delete();
    tick();
    redirect_valid = 1'b0;
    cyc = 0;
  endtask

  // wait for a window, score it, optionally stall, then accept (optionally with a redirect)
  task automatic take(input string tag, input int stall, input logic rdr, input logic [63:0] rpc);
    exp_t e;
    int n;
    logic [159:0] snap;
    n = 0;
    while (!inst_valid && n < 60) begin tick(); n++; end
    chk({tag, " valid"}, inst_valid, 1);
    if (exp_q.size() == 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s scoreboard: observed window, expected none", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " pc"},    inst_pc,      e.pc);
      chk({tag, " len"},   inst_len,     e.len);
      chk({tag, " bytes"}, inst_bytes,   e.bytes);
      chk({tag, " err"},   inst_err,     e.err);
      chk({tag, " ins"},   inst_ins_err, e.ins);
      if (e.vcyc >= 0) chk({tag, " cycle"}, cyc, e.vcyc);
    end
    snap = {9'd0, inst_valid, inst_pc, inst_len, inst_bytes, inst_err, inst_ins_err};
    for (int s = 0; s < stall; s++) begin
      chk({tag, " stall req"}, mem_req, 0);
      tick();
      chk({tag, " stable"}, {9'd0, inst_valid, inst_pc, inst_len, inst_bytes, inst_err, inst_ins_err}, snap);
    end
    inst_ready = 1'b1;
    if (rdr) begin redirect_valid = 1'b1; redirect_pc = rpc; req_log.delete(); end
    tick();
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    if (rdr) cyc = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_mem();
    repeat (2) @(negedge clk);
    chk("rst mem_req", mem_req, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst_pc", inst_pc, 0);
    chk("rst inst_bytes", inst_bytes, 0);
    chk("rst inst_len", inst_len, 0);
    chk("rst flags", {inst_err, inst_ins_err}, 0);

    // halt at 0: speculative byte 1, window in cycle 2, then silence
    push(64'd0, 4'd1, 80'h0, 1'b0, 1'b0, 2);
    rst = 1'b0;
    req_log.delete();
    tick(); cyc = 0;
    chk("t1 c0 req", mem_req, 1);
    chk("t1 c0 addr", mem_addr, 0);
    tick();
    chk("t1 c1 req", mem_req, 1);
    chk("t1 c1 addr", mem_addr, 1);
    take("t1 halt", 0, 1'b0, 64'd0);
    req_log.delete();
    repeat (6) tick();
    chk("t1 stop reqs", req_log.size(), 0);
    chk("t1 stop valid", inst_valid, 0);

    // irmovq then nop then halt
    mem[0] = 8'h30; mem[1] = 8'hF2; mem[2] = 8'h0A; mem[10] = 8'h10; mem[11] = 8'h00;
    push(64'd0,  4'd10, 80'h0000_0000_0000_000A_F230, 1'b0, 1'b0, 11);
    push(64'd10, 4'd1,  80'h10, 1'b0, 1'b0, 14);
    push(64'd11, 4'd1,  80'h00, 1'b0, 1'b0, 17);
    do_reset();
    take("t2 irmovq", 0, 1'b0, 64'd0);
    take("t2 nop", 0, 1'b0, 64'd0);
    take("t2 halt", 0, 1'b0, 64'd0);

    // backpressure on OPq
    clr_mem();
    mem[0] = 8'h60; mem[1] = 8'h23;
    push(64'd0, 4'd2, 80'h2360, 1'b0, 1'b0, 3);
    push(64'd2, 4'd1, 80'h00,   1'b0, 1'b0, 11);
    do_reset();
    take("t3 opq", 5, 1'b0, 64'd0);
    chk("t3 pc adv", inst_pc, 2);
`ifdef IFETCH_PERF_EN
    chk("t3 perf stall", perf_stall_cnt, 5);
    chk("t3 perf inst", perf_inst_cnt, 1);
`endif
    take("t3 halt", 0, 1'b0, 64'd0);

    // redirect while byte 4 of rmmovq is on the bus
    clr_mem();
    mem[0] = 8'h40; mem[1] = 8'h15;
    mem[2] = 8'h88; mem[3] = 8'h77; mem[4] = 8'h66; mem[5] = 8'h55;
    mem[6] = 8'h44; mem[7] = 8'h33; mem[8] = 8'h22; mem[9] = 8'h11;
    mem[64] = 8'h60; mem[65] = 8'h01; mem[66] = 8'h00;
    mem[16] = 8'h10; mem[17] = 8'h00;
    do_reset();
    repeat (4) tick();
    chk("t4 byte4 addr", mem_addr, 4);
    push(64'h40, 4'd2, 80'h0160, 1'b0, 1'b0, 3);
    push(64'h42, 4'd1, 80'h00,   1'b0, 1'b0, 6);
    redirect(64'h40);
    chk("t4 redir req", mem_req, 1);
    chk("t4 redir addr", mem_addr, 64'h40);
    chk("t4 redir pc", inst_pc, 64'h40);
    chk("t4 redir valid", inst_valid, 0);
    take("t4 addq", 0, 1'b0, 64'd0);
    take("t4 halt", 0, 1'b0, 64'd0);

    // address range: jmp at 1020 runs off the end of memory
    mem[1020] = 8'h70; mem[1021] = 8'h11; mem[1022] = 8'h22; mem[1023] = 8'h33;
    push(64'd1020, 4'd9, 80'h3322_1170, 1'b1, 1'b0, 5);
    redirect(64'd1020);
    take("t5 jmp", 0, 1'b0, 64'd0);
    chk("t5 req count", req_log.size(), 4);
    if (req_log.size() == 4) begin
      chk("t5 first addr", req_log[0], 1020);
      chk("t5 last addr", req_log[3], 1023);
    end
    req_log.delete();
    repeat (6) tick();
    chk("t5 stop reqs", req_log.size(), 0);
    push(64'd1024, 4'd1, 80'h0, 1'b1, 1'b0, 1);
    redirect(64'd1024);
    chk("t5 byte0 noreq", mem_req, 0);
    take("t5 byte0", 0, 1'b0, 64'd0);

    // invalid icode, STOP, restart by redirect
    mem[0] = 8'hF0;
    push(64'd0, 4'd1, 80'hF0, 1'b0, 1'b1, 2);
    redirect(64'd0);
    chk("t6 err cleared", {inst_err, inst_ins_err}, 0);
    take("t6 ins", 0, 1'b0, 64'd0);
    req_log.delete();
    repeat (5) tick();
    chk("t6 stop reqs", req_log.size(), 0);
    push(64'd0, 4'd1, 80'hF0, 1'b0, 1'b1, 2);
    redirect(64'd0);
    take("t6 restart", 0, 1'b0, 64'd0);

    // redirect coincident with acceptance wins over successor pc
    push(64'h40, 4'd2, 80'h0160, 1'b0, 1'b0, 3);
    push(64'h10, 4'd1, 80'h10,   1'b0, 1'b0, 2);
    push(64'h11, 4'd1, 80'h00,   1'b0, 1'b0, 5);
    redirect(64'h40);
    take("t7 addq", 0, 1'b1, 64'h10);
    chk("t7 pc", inst_pc, 64'h10);
    chk("t7 addr", mem_addr, 64'h10);
    take("t7 nop", 0, 1'b0, 64'd0);
    take("t7 halt", 0, 1'b0, 64'd0);

    chk("sb drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences a single-port, byte-wide, synchronous-read instruction memory for the Y86-64 pipeline fetch stage.
- Issues one byte read per cycle and decodes the instruction length from icode.
- Assembles up to 10 bytes into an instruction window and hands it to the fetch stage over a valid/ready handshake.
- Handles branch/return redirects, address-range errors, invalid icodes and halt.

Parameters:
RESET_PC, 64'd0, PC fetched after reset release
MEM_LAST, 64'd1023, highest legal byte address; any byte address above this is an imem error
MAX_LEN, 10, window size in bytes (fixed by ISA; not to be overridden)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_req  out  1  byte read strobe
mem_addr  out  64  byte address, valid when mem_req
mem_rdata  in  8  read data, valid the cycle after mem_req
redirect_valid  in  1  flush and restart at redirect_pc
redirect_pc  in  64  new fetch PC
inst_valid  out  1  window complete
inst_ready  in  1  fetch stage accepts window
inst_pc  out  64  PC of presented instruction
inst_bytes  out  80  byte k at [8k+7:8k]; bytes at index >= inst_len read as zero
inst_len  out  4  instruction length 1..10
inst_err  out  1  address error (imem_error)
inst_ins_err  out  1  invalid icode

Behaviour:
- Decided interface: one clock; reset is asynchronous and active-high. Ports are clk and rst.
- Reset values:
  - mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_pc=RESET_PC.
  - inst_bytes=0, inst_len=0, inst_err=0, inst_ins_err=0.
  - State FETCH with byte counters cleared.
- First mem_req occurs in the first clock cycle after rst deasserts. Call this cycle 0.
- Length by icode (byte0[7:4]):
  - 0, 1, 9 -> 1
  - 2, 6, A, B -> 2
  - 7, 8 -> 9
  - 3, 4, 5 -> 10
  - C..F -> 1, with inst_ins_err=1
- FETCH state:
  - Issue byte k at inst_pc+k in cycle k, capture it in cycle k+1.
  - Byte 1 is issued speculatively before the length is known; a returned byte with index >= len is discarded.
  - Issuing stops once k == len-1 has been issued.
  - Latency: inst_valid rises in cycle len+1. Halt -> cycle 2, irmovq -> cycle 11.
- HOLD state:
  - inst_valid=1; all inst_* outputs are stable until the cycle in which inst_valid && inst_ready is high.
  - On acceptance: inst_pc <= inst_pc+inst_len (64-bit wrap), inst_valid <= 0, inst_bytes cleared, and the next FETCH begins in the following cycle.
  - There is no overlap of the next fetch with HOLD.
- Address error:
  - If the byte address to issue exceeds MEM_LAST, do not assert mem_req for that byte.
  - Wait for outstanding data, then enter HOLD with inst_err=1 and inst_len set to the decoded value (1 if byte0 itself is illegal).
  - An out-of-range inst_pc (including byte 0) flags the error.
  - Address compare is 64-bit unsigned; PC+k wrap past 2^64-1 counts as an error.
- STOP state:
  - Entered on acceptance of a window with inst_err=1, inst_ins_err=1, or icode 0 (halt).
  - No mem_req and inst_valid=0. Leaves only on redirect or rst.
- Redirect (highest priority, any state):
  - In the cycle after redirect_valid: inst_valid=0, inst_pc=redirect_pc, mem_req=1 at redirect_pc, error flags cleared.
  - Any byte returning from a pre-redirect request is dropped.
  - Redirect in the same cycle as acceptance: redirect wins, and the accepted instruction's successor PC is discarded.
- Reset mid-operation: all state returns to reset values immediately; in-flight read data is ignored.

Optional Feature:
- Macro IFETCH_PERF_EN.
- When defined:
  - Adds output ports perf_inst_cnt[31:0], incremented on each acceptance.
  - Adds perf_stall_cnt[31:0], incremented each cycle with inst_valid=1 and inst_ready=0.
  - Both counters reset to 0 on rst, wrap at 2^32, and are not cleared by redirect.
- When undefined: these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Memory byte 0x00 at 0, inst_ready=1 -> mem_req at addr 0 in cycle 0 and addr 1 in cycle 1; inst_valid in cycle 2 with inst_len=1 and inst_bytes[7:0]=0x00; then STOP with no further mem_req.
- irmovq 30 F2 0A00000000000000 at 0, followed by nop 10 -> inst_valid in cycle 11, inst_len=10, inst_bytes=0x000000000000000AF230; next window at pc 10 with len 1.
- Backpressure: hold inst_ready=0 for 5 cycles on an OPq 60 23 -> outputs stable, mem_req=0 throughout, single acceptance, inst_pc advances by 2; with IFETCH_PERF_EN, perf_stall_cnt=5 and perf_inst_cnt=1.
- redirect_valid with redirect_pc=0x40 during byte 4 of an rmmovq -> next cycle mem_addr=0x40, late byte dropped, window presented for the instruction at 0x40 only.
- MEM_LAST=22, jmp 70 at pc 20 -> mem_req only for addresses 20..22; inst_valid with inst_err=1, inst_pc=20; after acceptance no mem_req until redirect.
- Byte 0xF0 at pc 0 -> inst_valid with inst_ins_err=1, inst_len=1; STOP after acceptance; redirect to 0 then restarts fetch.
